// File: rtl/alu_pkg.sv
// Shared opcode and result types for the accumulator ALU stage.
package alu_pkg;

    // Widest datapath the shared result struct can carry; instances narrower than this zero-extend.
    localparam int ALU_MAX_W = 64;

    typedef enum logic [2:0] {
        ADD  = 3'd0,
        SUB  = 3'd1,
        AND  = 3'd2,
        OR   = 3'd3,
        XOR  = 3'd4,
        PASS = 3'd5,
        SHL  = 3'd6,
        CLR  = 3'd7
    } alu_op_e;

    typedef struct packed {
        logic [ALU_MAX_W-1:0] data;
        logic                 zero;
        logic                 carry;
        logic                 ovf;
    } alu_res_t;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: next accumulator value and flags from (acc, op, opcode).
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] op,
    input  alu_op_e          opcode,
    output alu_res_t         res
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             ovf;

    assign sum  = {1'b0, acc} + {1'b0, op};
    // The extra top bit of the unsigned difference is the borrow, i.e. acc < op.
    assign diff = {1'b0, acc} - {1'b0, op};

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        result = '0;
        carry  = 1'b0;
        ovf    = 1'b0;
        unique case (opcode)
            ADD: begin
                result = sum[WIDTH-1:0];
                carry  = sum[WIDTH];
                ovf    = (acc[WIDTH-1] == op[WIDTH-1]) && (sum[WIDTH-1] != acc[WIDTH-1]);
            end
            SUB: begin
                result = diff[WIDTH-1:0];
                carry  = diff[WIDTH];
                ovf    = (acc[WIDTH-1] != op[WIDTH-1]) && (diff[WIDTH-1] != acc[WIDTH-1]);
            end
            AND:  result = acc & op;
            OR:   result = acc | op;
            XOR:  result = acc ^ op;
            PASS: result = op;
            SHL: begin
                result = acc << 1;
                carry  = acc[WIDTH-1];
            end
            CLR:  result = '0;
        endcase
    end

    assign res = '{
        data:  ALU_MAX_W'(result),
        zero:  (result == '0),
        carry: carry,
        ovf:   ovf
    };

endmodule

// File: rtl/mux_alu_stage.sv
// Two-stage valid/ready accumulator ALU: S1 captures operand/opcode, S2 computes and registers the result.
module mux_alu_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  alu_op_e          in_op,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero,
    output logic             out_carry,
    output logic             out_ovf,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] res_count
);

    logic             s1_valid;
    logic [WIDTH-1:0] s1_data;
    alu_op_e          s1_op;
    logic [WIDTH-1:0] acc;
    logic             s2_advance;
    alu_res_t         alu_res;
    logic             unused_res_data;

    assign s2_advance = !out_valid || out_ready;
    assign in_ready   = !s1_valid || s2_advance;

    alu_core #(.WIDTH(WIDTH)) u_alu_core (
        .acc    (acc),
        .op     (s1_data),
        .opcode (s1_op),
        .res    (alu_res)
    );

    // Bits above WIDTH are zero-extension of the shared result type.
    assign unused_res_data = ^alu_res.data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_op    <= ADD;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_data <= in_data;
                s1_op   <= in_op;
            end
        end
    end

    // acc moves in lock-step with the output register, so the next op in S1 always sees it updated.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            acc       <= '0;
            out_data  <= '0;
            out_zero  <= 1'b0;
            out_carry <= 1'b0;
            out_ovf   <= 1'b0;
        end else if (s2_advance) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                acc       <= alu_res.data[WIDTH-1:0];
                out_data  <= alu_res.data[WIDTH-1:0];
                out_zero  <= alu_res.zero;
                out_carry <= alu_res.carry;
                out_ovf   <= alu_res.ovf;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            res_count <= '0;
        end else if (out_valid && out_ready && (res_count != '1)) begin
            res_count <= res_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_mux_alu_stage.sv
// Scoreboard bench for mux_alu_stage: arithmetic reference model, directed cases and randomized traffic.
module tb_mux_alu_stage;
    import alu_pkg::*;

    localparam int W       = 8;
    localparam int CW      = 4;
    localparam int CNT_MAX = 15;

    typedef struct packed {
        logic [W-1:0] data;
        logic         zero;
        logic         carry;
        logic         ovf;
    } exp_t;

    logic          clk;
    logic          rst;
    logic [W-1:0]  in_data;
    alu_op_e       in_op;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  out_data;
    logic          out_zero;
    logic          out_carry;
    logic          out_ovf;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] res_count;

    exp_t sb[$];
    exp_t last_out;
    int   checks;
    int   errors;
    int   model_acc;
    int   consumed;
    int   accepted;
    bit   rand_ready;

    mux_alu_stage #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_op     (in_op),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_zero  (out_zero),
        .out_carry (out_carry),
        .out_ovf   (out_ovf),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res_count (res_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on the running accumulator value.
    function automatic exp_t model(input alu_op_e opc, input int op);
        int   a;
        int   r;
        int   sa;
        int   so;
        int   sr;
        exp_t e;
        a  = model_acc;
        sa = (a >= 2 ** (W - 1)) ? a - 2 ** W : a;
        so = (op >= 2 ** (W - 1)) ? op - 2 ** W : op;
        e.carry = 1'b0;
        e.ovf   = 1'b0;
        r  = 0;
        sr = 0;
        case (opc)
            ADD: begin
                r = a + op;
                e.carry = (r >= 2 ** W);
                sr = sa + so;
                e.ovf = (sr > 2 ** (W - 1) - 1) || (sr < -(2 ** (W - 1)));
            end
            SUB: begin
                r = a - op;
                e.carry = (a < op);
                sr = sa - so;
                e.ovf = (sr > 2 ** (W - 1) - 1) || (sr < -(2 ** (W - 1)));
            end
            AND:  r = a & op;
            OR:   r = a | op;
            XOR:  r = a ^ op;
            PASS: r = op;
            SHL: begin
                r = a * 2;
                e.carry = (a >= 2 ** (W - 1));
            end
            default: r = 0;
        endcase
        if (r < 0) r = r + 2 ** W;
        r = r % (2 ** W);
        model_acc = r;
        e.data = r[W-1:0];
        e.zero = (r == 0);
        return e;
    endfunction

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input alu_op_e opc, input int val);
        bit done;
        done     = 1'b0;
        in_op    = opc;
        in_data  = val[W-1:0];
        in_valid = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(model(opc, val));
                accepted++;
                done = 1'b1;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready stayed 0 for op %0d", opc);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clk);
            if (sb.size() == 0) done = 1'b1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s_drain: %0d results still pending", name, sb.size());
        end
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1: asserts reset asynchronously mid-cycle, releases it one cycle later.
    task automatic apply_reset();
        #2;
        rst = 1'b0;
        sb.delete();
        model_acc = 0;
        consumed  = 0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_res_count", res_count, 0);
        check("rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // Monitor: a negedge with out_valid && out_ready means a transfer at the next rising edge.
    always @(negedge clk) begin
        if (rst) begin
            check("res_count", res_count, (consumed > CNT_MAX) ? CNT_MAX : consumed);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got 0x%0h with empty scoreboard", out_data);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("out_data", out_data, e.data);
                    check("out_zero", out_zero, e.zero);
                    check("out_carry", out_carry, e.carry);
                    check("out_ovf", out_ovf, e.ovf);
                end
                last_out = '{data: out_data, zero: out_zero, carry: out_carry, ovf: out_ovf};
                consumed++;
            end
        end
    end

    always @(posedge clk) begin
        if (rand_ready) begin
            #1;
            out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        time t0;
        checks     = 0;
        errors     = 0;
        model_acc  = 0;
        consumed   = 0;
        accepted   = 0;
        rand_ready = 1'b0;
        last_out   = '0;
        rst        = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        in_op      = ADD;
        out_ready  = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_res_count", res_count, 0);
        check("reset_out_data", out_data, 0);
        check("reset_flags", {out_zero, out_carry, out_ovf}, 0);
        rst = 1'b1;

        // Accept on the first edge after release; result registered one edge later.
        send(PASS, 'h3C);
        check("lat_s1_out_valid", out_valid, 0);
        @(posedge clk);
        #1;
        check("lat_s2_out_valid", out_valid, 1);
        check("lat_s2_out_data", out_data, 'h3C);
        drain("pass3c");
        check("pass3c_data", last_out.data, 'h3C);
        check("pass3c_flags", {last_out.zero, last_out.carry}, 0);
        check("pass3c_count", res_count, 1);

        send(PASS, 'h20);
        send(ADD, 'hF0);
        drain("add_carry");
        check("add_carry_data", last_out.data, 'h10);
        check("add_carry_flags", {last_out.carry, last_out.ovf}, 2'b10);

        send(PASS, 'h7F);
        send(ADD, 'h01);
        drain("add_ovf");
        check("add_ovf_data", last_out.data, 'h80);
        check("add_ovf_flags", {last_out.carry, last_out.ovf}, 2'b01);
        send(SUB, 'h80);
        drain("sub_zero");
        check("sub_zero_data", last_out.data, 'h00);
        check("sub_zero_flags", {last_out.zero, last_out.carry}, 2'b10);

        send(PASS, 'h05);
        send(SUB, 'h06);
        drain("sub_borrow");
        check("sub_borrow_data", last_out.data, 'hFF);
        check("sub_borrow_carry", last_out.carry, 1);
        send(SHL, 'h00);
        drain("shl");
        check("shl_data", last_out.data, 'hFE);
        check("shl_carry", last_out.carry, 1);

        // Back-to-back accepts with out_ready held high: one op per cycle.
        t0 = $time;
        send(PASS, 'h11);
        send(XOR, 'hFF);
        send(AND, 'h0F);
        send(CLR, 'h55);
        check("throughput", ($time - t0) / 10, 4);
        drain("burst");
        check("clr_zero", last_out.zero, 1);

        // Backpressure: S1 and S2 fill, third op must wait.
        apply_reset();
        out_ready = 1'b0;
        accepted  = 0;
        fork
            begin
                send(PASS, 'h01);
                send(ADD, 'h01);
                send(ADD, 'h01);
            end
        join_none
        repeat (5) @(posedge clk);
        #1;
        check("stall_accepted", accepted, 2);
        check("stall_in_ready", in_ready, 0);
        check("stall_out_valid", out_valid, 1);
        check("stall_out_data", out_data, 'h01);
        out_ready = 1'b1;
        drain("stall");
        wait fork;
        check("stall_accepted_all", accepted, 3);
        check("stall_last_data", last_out.data, 'h03);
        check("stall_count", res_count, 3);

        // Reset with two ops in flight.
        send(PASS, 'h40);
        send(ADD, 'h02);
        check("inflight_out_valid", out_valid, 1);
        apply_reset();
        send(ADD, 'h09);
        drain("post_reset");
        check("post_reset_data", last_out.data, 'h09);

        // Randomized traffic with random downstream backpressure.
        rand_ready = 1'b1;
        for (int n = 0; n < 300; n++) begin
            send(alu_op_e'($urandom_range(0, 7)), int'($urandom_range(0, 255)));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        rand_ready = 1'b0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        drain("random");
        check("res_count_saturated", res_count, CNT_MAX);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_alu_stage.md
MUX_ALU_STAGE -- requirements
Module: mux_alu_stage

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: operand, accumulator and result width.
REQ-002 The block SHALL have parameter CNT_W, default 16: width of the result counter.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-004 The ports SHALL be:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-low reset.
- in_data  in  WIDTH  operand; the upstream mux "out" connects here.
- in_op  in  3  opcode of type alu_op_e.
- in_valid  in  1  operand/opcode valid.
- in_ready  out  1  stage can accept.
- out_data  out  WIDTH  result.
- out_zero  out  1  result == 0.
- out_carry  out  1  carry/borrow.
- out_ovf  out  1  signed overflow.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts.
- res_count  out  CNT_W  results consumed so far.

Function
REQ-005 A transfer SHALL occur on a rising clk edge when valid and ready are both 1 on that interface.
REQ-006 The pipeline SHALL have two registered stages: S1 (operand/opcode capture) and S2 (compute, accumulator update, output register).
REQ-007 The accepted-input to out_valid latency SHALL be 2 cycles with no backpressure.
REQ-008 Sustained throughput SHALL be 1 op/cycle.
REQ-009 S2 SHALL advance when !out_valid || out_ready.
REQ-010 S1 SHALL advance into S2 only when S2 advances.
REQ-011 in_ready SHALL equal !s1_valid || s2_advance, combinationally and without depending on in_valid.
REQ-012 The opcodes SHALL compute as follows, with the result written to both acc and out_data:
- ADD: acc + op.
- SUB: acc - op.
- AND, OR, XOR: acc with op.
- PASS: op.
- SHL: acc << 1, op ignored.
- CLR: 0.
REQ-013 The accumulator SHALL update only when an S1 entry moves into S2, once per op; the next op SHALL see the updated acc with no hazard.
REQ-014 ADD carry SHALL be bit WIDTH of the unsigned (WIDTH+1)-bit sum.
REQ-015 SUB carry SHALL be 1 iff acc < op (borrow).
REQ-016 SHL carry SHALL be the old acc MSB.
REQ-017 Carry SHALL be 0 for all other ops.
REQ-018 out_ovf SHALL be two's-complement overflow for ADD/SUB only, and 0 otherwise.
REQ-019 out_zero SHALL be set iff out_data == 0, for every op.
REQ-020 Arithmetic SHALL wrap modulo 2^WIDTH.
REQ-021 While out_valid && !out_ready, out_data and the flags SHALL hold stable and acc SHALL NOT change.
REQ-022 res_count SHALL increment on each out_valid && out_ready and saturate at all-ones.
REQ-023 An input offered while S1 is full and S2 is stalled SHALL NOT be accepted (in_ready = 0), and no data SHALL be lost or reordered.
REQ-024 A simultaneous output consume and input accept in the same cycle SHALL both complete.

Reset
REQ-025 On rst low, the block SHALL asynchronously force all of the following to 0: s1_valid, out_valid, acc, out_data, out_zero, out_carry, out_ovf, res_count.
REQ-026 in_ready SHALL be 1 during and after reset.
REQ-027 Reset asserted mid-operation SHALL discard all in-flight ops; the first op after release SHALL see acc = 0.
REQ-028 Reset release SHALL be synchronous to clk; the first accept SHALL be possible on the first edge after release.

Structure
REQ-029 Package alu_pkg SHALL hold typedef enum logic [2:0] alu_op_e with ADD=0, SUB=1, AND=2, OR=3, XOR=4, PASS=5, SHL=6, CLR=7.
REQ-030 Package alu_pkg SHALL hold a packed result struct {data, zero, carry, ovf}.
REQ-031 A combinational sub-module alu_core SHALL compute (acc, op, opcode) -> result struct; the sequencing and handshake SHALL stay in mux_alu_stage.

Verification (WIDTH=8, out_ready=1 unless stated)
REQ-032 Reset, then PASS 0x3C -> out_data 0x3C two cycles after accept, zero 0, carry 0, res_count 1.
REQ-033 PASS 0x20, then ADD 0xF0 -> second result 0x10, carry 1, ovf 0.
REQ-034 PASS 0x7F, then ADD 0x01 -> 0x80, ovf 1, carry 0; then SUB 0x80 -> 0x00, zero 1, carry 0.
REQ-035 PASS 0x05, then SUB 0x06 -> 0xFF, carry 1; then SHL -> 0xFE, carry 1.
REQ-036 out_ready=0 for 5 cycles, with PASS 0x01, ADD 0x01, ADD 0x01 offered back-to-back:
- exactly 2 are accepted, then in_ready = 0.
- out_data holds 0x01.
- after out_ready=1, outputs 0x01, 0x02, 0x03 appear in order, and res_count = 3.
REQ-037 rst low while 2 ops are in flight -> out_valid drops immediately, res_count = 0; after release, ADD 0x09 -> 0x09.
